// File: rtl/rf_write_queue.sv
// rf_write_queue: circular FIFO of pending register-file writes with youngest-match forwarding.
// Ports: clk, reset (sync, active-high);
//   producer  : in_valid, in_ready, in_addr, in_data (address 0 is accepted and dropped);
//   write port: port_free, we3, wa3, wd3 (head entry, popped whenever we3 is high);
//   lookups   : ra1/ra2 -> fwd1_hit/fwd1_data, fwd2_hit/fwd2_data;
//   count     : number of valid entries.
module rf_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_addr,
    input  logic [31:0]            in_data,
    input  logic                   port_free,
    output logic                   we3,
    output logic [4:0]             wa3,
    output logic [31:0]            wd3,
    input  logic [4:0]             ra1,
    input  logic [4:0]             ra2,
    output logic                   fwd1_hit,
    output logic [31:0]            fwd1_data,
    output logic                   fwd2_hit,
    output logic [31:0]            fwd2_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic          push, nonempty;

    assign nonempty = count != '0;
    assign in_ready = count < FULL;
    assign push     = in_valid && in_ready && in_addr != 5'd0;
    assign we3      = port_free && nonempty;
    assign wa3      = nonempty ? addr_mem[head] : 5'd0;
    assign wd3      = nonempty ? data_mem[head] : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                addr_mem[tail] <= in_addr;
                data_mem[tail] <= in_data;
                tail           <= tail + 1'b1;
            end
            if (we3)
                head <= head + 1'b1;
            if (push != we3)
                count <= push ? count + 1'b1 : count - 1'b1;
        end
    end

    // Walk valid entries oldest to youngest so the last match wins (youngest value).
    always_comb begin
        logic [AW-1:0] idx;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        idx       = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if ((AW+1)'(i) < count) begin
                if (ra1 != 5'd0 && addr_mem[idx] == ra1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = data_mem[idx];
                end
                if (ra2 != 5'd0 && addr_mem[idx] == ra2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = data_mem[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_rf_write_queue.sv
// tb_rf_write_queue: randomized + directed scoreboard bench for rf_write_queue.
module tb_rf_write_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, port_free, we3;
    logic        fwd1_hit, fwd2_hit;
    logic [4:0]  in_addr, wa3, ra1, ra2;
    logic [31:0] in_data, wd3, fwd1_data, fwd2_data;
    logic [2:0]  count;

    rf_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .port_free(port_free),
        .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        in_ready, we3, h1, h2;
        logic [2:0]  count;
        logic [4:0]  wa3;
        logic [31:0] wd3, d1, d2;
    } exp_t;

    exp_t        chk_q[$];
    logic [36:0] pend[$];   // pending writes, oldest first: {addr, data}
    int          checks = 0;
    int          failures = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: compares what the DUT presents mid-cycle against the queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (chk_q.size() != 0) begin
            e = chk_q.pop_front();
            cmp("in_ready", 32'(in_ready), 32'(e.in_ready));
            cmp("count", 32'(count), 32'(e.count));
            cmp("we3", 32'(we3), 32'(e.we3));
            cmp("wa3", 32'(wa3), 32'(e.wa3));
            cmp("wd3", wd3, e.wd3);
            cmp("fwd1_hit", 32'(fwd1_hit), 32'(e.h1));
            cmp("fwd1_data", fwd1_data, e.d1);
            cmp("fwd2_hit", 32'(fwd2_hit), 32'(e.h2));
            cmp("fwd2_data", fwd2_data, e.d2);
        end
    end

    function automatic void lookup(input logic [4:0] ra, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (ra != 5'd0)
            for (int i = pend.size() - 1; i >= 0 && !hit; i--)
                if (pend[i][36:32] == ra) begin
                    hit = 1'b1;
                    d   = pend[i][31:0];
                end
    endfunction

    // One clock cycle: drive inputs, queue the expected view, then advance the model past the edge.
    task automatic step(input logic rs, input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic pf, input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        logic acc, pop;
        reset = rs; in_valid = v; in_addr = a; in_data = d; port_free = pf; ra1 = r1; ra2 = r2;
        e.count    = 3'(pend.size());
        e.in_ready = pend.size() < DEPTH;
        e.we3      = pf && pend.size() != 0;
        e.wa3      = pend.size() != 0 ? pend[0][36:32] : 5'd0;
        e.wd3      = pend.size() != 0 ? pend[0][31:0] : 32'd0;
        lookup(r1, e.h1, e.d1);
        lookup(r2, e.h2, e.d2);
        chk_q.push_back(e);
        acc = v && pend.size() < DEPTH;
        pop = pf && pend.size() != 0;
        @(posedge clk);
        #1;
        if (rs)
            pend.delete();
        else begin
            if (pop) void'(pend.pop_front());
            if (acc && a != 5'd0) pend.push_back({a, d});
        end
    endtask

    task automatic idle(input logic pf);
        step(0, 0, 0, 0, pf, 0, 0);
    endtask

    initial begin
        reset = 1; in_valid = 0; in_addr = 0; in_data = 0; port_free = 0; ra1 = 0; ra2 = 0;
        repeat (2) @(posedge clk);
        #1;
        idle(1);
        // single write
        step(0, 1, 5, 32'h1234, 1, 5, 0);
        step(0, 0, 0, 0, 1, 5, 0);
        idle(1);
        // fill while stalled, fifth push held, then drain
        for (int a = 1; a <= 4; a++) step(0, 1, 5'(a), 32'(a) * 16, 0, 5'(a), 1);
        step(0, 1, 5, 32'h55aa, 0, 4, 2);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 3, 4);
        // forwarding picks youngest match
        step(0, 1, 7, 32'hA, 0, 0, 0);
        step(0, 1, 3, 32'hB, 0, 0, 0);
        step(0, 1, 7, 32'hC, 0, 7, 3);
        step(0, 0, 0, 0, 0, 7, 3);
        step(0, 0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 7, 3);
        // zero register discarded
        step(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0);
        idle(1);
        // full with simultaneous pop, then wrap over several DEPTH cycles
        for (int a = 1; a <= 4; a++) step(0, 1, 5'(a + 10), 32'(a), 0, 0, 0);
        step(0, 1, 6, 32'h66, 1, 6, 11);
        step(0, 1, 6, 32'h66, 1, 6, 12);
        for (int i = 0; i < 3 * DEPTH; i++) step(0, 1, 5'(i + 1), 32'(i + 100), 1, 5'(i), 6);
        for (int i = 0; i < 5; i++) idle(1);
        // reset mid-operation
        for (int a = 1; a <= 3; a++) step(0, 1, 5'(a + 20), 32'(a), 0, 21, 22);
        step(1, 1, 8, 32'h88, 1, 21, 22);
        step(0, 1, 9, 32'h55, 1, 21, 9);
        step(0, 0, 0, 0, 1, 9, 0);
        idle(1);
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom % 64) == 0, $urandom % 2, 5'($urandom % 8), $urandom,
                 ($urandom % 3) != 0, 5'($urandom % 8), 5'($urandom % 8));
        idle(1);
        repeat (4) @(negedge clk);
        if (chk_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", chk_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
